ps2_ascii_fifo: RTL and testbench
=================================

# ps2_ascii_fifo

PS/2 keyboard front end that feeds the PicoBlaze input port. It filters the PS/2 clock, deserialises 11-bit device-to-host frames, and tracks make, break (F0) and extended (E0) prefixes. Make codes are translated to ASCII and queued in a small show-ahead FIFO, which raises `interrupt` while non-empty and pops on the `DoRead` (interrupt_ack) pulse.

## Interface
- `FILTER_LEN`, 8: length of the ps2c glitch-filter shift register (cycles).
- `TIMEOUT`, 200000: idle cycles between falling edges before an in-progress frame is abandoned.
- `FIFO_AW`, 2: FIFO address width; depth = 2**FIFO_AW.
- `clk`  in  1  system clock (100 MHz).
- `Reset`  in  1  asynchronous, active-low reset.
- `ps2d`  in  1  PS/2 data, asynchronous.
- `ps2c`  in  1  PS/2 clock, asynchronous.
- `DoRead`  in  1  single-cycle pop strobe from PicoBlaze interrupt_ack.
- `ascii_code`  out  8  head of FIFO; 0x00 when empty.
- `interrupt`  out  1  high while FIFO non-empty.
- `overflow`  out  1  sticky; set when a code is dropped on full FIFO.
- `frame_err`  out  1  one-cycle pulse on a rejected frame or timeout.

## Operation
- Synchroniser: two flops on ps2c and ps2d. Filter: shift register of `FILTER_LEN` samples. Filtered clock goes 0 when all samples are 0 and 1 when all are 1; otherwise it holds. Edge strobe `fall` is one cycle on the filtered 1→0 transition.
- RX FSM, sampling synchronised ps2d on `fall`:
  - IDLE: start bit 0 → DATA; start bit 1 → stay in IDLE, no error.
  - DATA: 8 bits, LSB first → PARITY.
  - PARITY: capture bit → STOP.
  - STOP: bit 1 → emit byte; bit 0 → `frame_err`. Either case → IDLE.
  - Timeout: a timer counts cycles without `fall` outside IDLE. At `TIMEOUT` → IDLE, `frame_err`, partial byte discarded.
- Decoder, on each emitted byte:
  - 0xE0 sets `ext`.
  - 0xF0 sets `brk`.
  - Any other byte: if `brk`, discard it. Otherwise translate and push if mapped. Unmapped codes are dropped silently. Both flags clear after any non-prefix byte.
- Translation, non-extended (Set 2):
  - Letters A–Z → 0x41–0x5A (uppercase only).
  - Digits 0–9: 45,16,1E,26,25,2E,36,3D,3E,46 → 0x30–0x39.
  - 0x29 → 0x20, 0x5A → 0x0D, 0x66 → 0x08.
- Translation, extended: 75 → 0x80 (up), 72 → 0x81 (down), 6B → 0x82 (left), 74 → 0x83 (right). Extended codes outside this list are dropped.
- FIFO, show-ahead, 4 entries by default. `ascii_code` is the registered head.
  - `DoRead` while empty is ignored.
  - Push while full: new code dropped, `overflow` set. `overflow` clears on the next accepted pop.
  - Simultaneous push and pop: both take effect, including when full (count unchanged, no overflow).
  - Pointers wrap modulo depth. The count has FIFO_AW+1 bits.

## Timing
- Reset values: `ascii_code` = 0x00, `interrupt` = 0, `overflow` = 0, `frame_err` = 0. FSM in IDLE; `ext`, `brk`, timer and FIFO cleared.
- Reset asserted mid-frame aborts the frame; nothing is pushed.
- Raw ps2c falling edge to `fall`: 2 sync + `FILTER_LEN` + 1 cycles.
- Let N be the cycle in which `fall` samples the stop bit:
  - The decoded code is registered at the end of N+1.
  - The FIFO write occurs at the end of N+2.
  - `interrupt` and `ascii_code` are valid from cycle N+3.
- `DoRead` sampled high in cycle M: the next head, or 0x00 and `interrupt` = 0, appears in M+1.
- `frame_err` is high for exactly the cycle after the error is detected.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: odd parity is checked over data+parity. A mismatch drops the frame and pulses `frame_err`.
- Undefined: the parity bit is captured and ignored. Only start, stop and timeout errors are reported.

## Test plan
- Frame 0x1C with good parity → `interrupt` = 1 and `ascii_code` = 0x41 at N+3. `DoRead` pulse → `interrupt` = 0 and `ascii_code` = 0x00 next cycle.
- Sequence 1C, F0, 1C → exactly one entry 0x41. Sequence E0 6B, E0 F0 6B → one entry 0x82.
- Six make codes 16,1E,26,25,2E,36 with no reads → FIFO holds 0x31–0x34 and `overflow` = 1. Four pops return 0x31, 0x32, 0x33, 0x34 in order; `overflow` clears on the first pop.
- Full FIFO with `DoRead` coincident with a push cycle → count stays 4 and `overflow` stays 0.
- Frame 0x1C with flipped parity → with `PS2_PARITY_CHECK_EN`: no push, one-cycle `frame_err`. Without the macro: 0x41 is pushed.
- Stop ps2c after 5 data bits → `frame_err` after `TIMEOUT` cycles. A following valid 0x29 frame yields 0x20. `Reset` low mid-frame → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/ps2_ascii_fifo.sv
// ps2_ascii_fifo
//   PS/2 keyboard front end for the PicoBlaze input port. Filters the PS/2
//   clock, deserialises 11-bit device-to-host frames, tracks the E0 (extended)
//   and F0 (break) prefixes, translates make codes to ASCII and queues them in
//   a show-ahead FIFO that raises `interrupt` while non-empty.
//
//   Build option: PS2_PARITY_CHECK_EN -- when defined, odd parity over
//   data+parity is checked and a mismatching frame is dropped with frame_err.
//   When undefined the parity bit is captured and ignored.
//
// Ports
//   clk        in   system clock
//   Reset      in   asynchronous, active-low reset
//   ps2d       in   PS/2 data (asynchronous)
//   ps2c       in   PS/2 clock (asynchronous)
//   DoRead     in   single-cycle pop strobe (interrupt_ack)
//   ascii_code out  registered FIFO head, 0x00 when empty
//   interrupt  out  high while FIFO non-empty
//   overflow   out  sticky drop flag, cleared by the next accepted pop
//   frame_err  out  one-cycle pulse on rejected frame or timeout
//
// RX states
//   state     | meaning
//   ST_IDLE   | waiting for a start bit (0) on a filtered falling edge
//   ST_DATA   | shifting in 8 data bits, LSB first
//   ST_PARITY | capturing the parity bit
//   ST_STOP   | checking the stop bit, emitting the byte or flagging an error

module ps2_ascii_fifo #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 200000,
  parameter int FIFO_AW    = 2
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       ps2d,
  input  logic       ps2c,
  input  logic       DoRead,
  output logic [7:0] ascii_code,
  output logic       interrupt,
  output logic       overflow,
  output logic       frame_err
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} rx_state_e;

  // ---------------- synchroniser and glitch filter ----------------
  logic                  ps2c_s1_q, ps2c_s2_q, ps2d_s1_q, ps2d_s2_q;
  logic [FILTER_LEN-1:0] filt_q;
  logic                  filt_clk_q, filt_clk_d;
  logic                  all0, all1, fall;

  assign all0 = (filt_q == '0);
  assign all1 = &filt_q;
  assign fall = filt_clk_q & all0;

  always_comb begin
    filt_clk_d = filt_clk_q;
    if (all1)      filt_clk_d = 1'b1;
    else if (all0) filt_clk_d = 1'b0;
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      ps2c_s1_q  <= 1'b1;
      ps2c_s2_q  <= 1'b1;
      ps2d_s1_q  <= 1'b1;
      ps2d_s2_q  <= 1'b1;
      filt_q     <= '1;
      filt_clk_q <= 1'b1;
    end else begin
      ps2c_s1_q  <= ps2c;
      ps2c_s2_q  <= ps2c_s1_q;
      ps2d_s1_q  <= ps2d;
      ps2d_s2_q  <= ps2d_s1_q;
      filt_q     <= {filt_q[FILTER_LEN-2:0], ps2c_s2_q};
      filt_clk_q <= filt_clk_d;
    end
  end

  // ---------------- RX frame FSM ----------------
  rx_state_e     state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    sh_q, sh_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          emit, err, parity_ok;
  logic [7:0]    rx_byte_q;
  logic          rx_vld_q, frame_err_q;

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^{sh_q, par_q};
`else
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    par_d     = par_q;
    emit      = 1'b0;
    err       = 1'b0;
    case (state_q)
      ST_IDLE:   if (fall && !ps2d_s2_q) begin
                   state_d   = ST_DATA;
                   bit_cnt_d = '0;
                 end
      ST_DATA:   if (fall) begin
                   sh_d      = {ps2d_s2_q, sh_q[7:1]};
                   bit_cnt_d = bit_cnt_q + 3'd1;
                   if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                 end
      ST_PARITY: if (fall) begin
                   par_d   = ps2d_s2_q;
                   state_d = ST_STOP;
                 end
      ST_STOP:   if (fall) begin
                   state_d = ST_IDLE;
                   if (ps2d_s2_q && parity_ok) emit = 1'b1;
                   else                        err  = 1'b1;
                 end
      default:   state_d = ST_IDLE;
    endcase
    // Down-counting watchdog, reloaded on every edge and while idle.
    tmr_d = TW'(TIMEOUT - 1);
    if (state_q != ST_IDLE && !fall) begin
      if (tmr_q == '0) begin
        state_d = ST_IDLE;
        err     = 1'b1;
      end else begin
        tmr_d = tmr_q - TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      sh_q        <= '0;
      par_q       <= 1'b0;
      tmr_q       <= TW'(TIMEOUT - 1);
      rx_byte_q   <= '0;
      rx_vld_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sh_q        <= sh_d;
      par_q       <= par_d;
      tmr_q       <= tmr_d;
      if (emit) rx_byte_q <= sh_q;
      rx_vld_q    <= emit;
      frame_err_q <= err;
    end
  end

  // ---------------- prefix tracking and translation ----------------
  function automatic logic [7:0] xlate(input logic [8:0] c);
    case (c)
      9'h01C: return 8'h41;  9'h032: return 8'h42;  9'h021: return 8'h43;
      9'h023: return 8'h44;  9'h024: return 8'h45;  9'h02B: return 8'h46;
      9'h034: return 8'h47;  9'h033: return 8'h48;  9'h043: return 8'h49;
      9'h03B: return 8'h4A;  9'h042: return 8'h4B;  9'h04B: return 8'h4C;
      9'h03A: return 8'h4D;  9'h031: return 8'h4E;  9'h044: return 8'h4F;
      9'h04D: return 8'h50;  9'h015: return 8'h51;  9'h02D: return 8'h52;
      9'h01B: return 8'h53;  9'h02C: return 8'h54;  9'h03C: return 8'h55;
      9'h02A: return 8'h56;  9'h01D: return 8'h57;  9'h022: return 8'h58;
      9'h035: return 8'h59;  9'h01A: return 8'h5A;
      9'h045: return 8'h30;  9'h016: return 8'h31;  9'h01E: return 8'h32;
      9'h026: return 8'h33;  9'h025: return 8'h34;  9'h02E: return 8'h35;
      9'h036: return 8'h36;  9'h03D: return 8'h37;  9'h03E: return 8'h38;
      9'h046: return 8'h39;
      9'h029: return 8'h20;  9'h05A: return 8'h0D;  9'h066: return 8'h08;
      9'h175: return 8'h80;  9'h172: return 8'h81;  9'h16B: return 8'h82;
      9'h174: return 8'h83;
      default: return 8'h00;  // unmapped: every mapped value is non-zero
    endcase
  endfunction

  logic       ext_q, ext_d, brk_q, brk_d;
  logic [7:0] code_q, code_d;
  logic       code_vld_q, code_vld_d;

  always_comb begin
    ext_d      = ext_q;
    brk_d      = brk_q;
    code_d     = code_q;
    code_vld_d = 1'b0;
    if (rx_vld_q) begin
      if (rx_byte_q == 8'hE0)      ext_d = 1'b1;
      else if (rx_byte_q == 8'hF0) brk_d = 1'b1;
      else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (!brk_q) begin
          code_d     = xlate({ext_q, rx_byte_q});
          code_vld_d = (code_d != 8'h00);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      code_q     <= '0;
      code_vld_q <= 1'b0;
    end else begin
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      code_q     <= code_d;
      code_vld_q <= code_vld_d;
    end
  end

  // ---------------- show-ahead FIFO ----------------
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [7:0]         head_q, head_d;
  logic               irq_q, ovf_q, ovf_d;
  logic               pop, push_ok, drop, full;

  assign full    = (cnt_q == CW'(DEPTH));
  assign pop     = DoRead && (cnt_q != '0);
  assign push_ok = code_vld_q && (!full || pop);
  assign drop    = code_vld_q && full && !pop;

  always_comb begin
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (push_ok && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!push_ok && pop) cnt_d = cnt_q - CW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      ovf_d    = 1'b0;
    end else if (drop) begin
      ovf_d    = 1'b1;
    end
    // Registered head: the entry being written this cycle may become the head.
    if (cnt_d == '0)                          head_d = 8'h00;
    else if (push_ok && wr_ptr_q == rd_ptr_d) head_d = code_q;
    else                                      head_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= code_q;
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= 8'h00;
      irq_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
      irq_q    <= (cnt_d != '0);
      ovf_q    <= ovf_d;
    end
  end

  assign ascii_code = head_q;
  assign interrupt  = irq_q;
  assign overflow   = ovf_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_ascii_fifo.sv
module tb_ps2_ascii_fifo;

  localparam int F     = 8;
  localparam int TO    = 1000;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic       clk = 1'b0, Reset = 1'b0, ps2d = 1'b1, ps2c = 1'b1, DoRead = 1'b0;
  logic [7:0] ascii_code;
  logic       interrupt, overflow, frame_err;

  ps2_ascii_fifo #(.FILTER_LEN(F), .TIMEOUT(TO), .FIFO_AW(AW)) dut (
    .clk(clk), .Reset(Reset), .ps2d(ps2d), .ps2c(ps2c), .DoRead(DoRead),
    .ascii_code(ascii_code), .interrupt(interrupt), .overflow(overflow),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int fe_cnt = 0;
  always @(posedge clk) if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] map_n [logic [7:0]];
  logic [7:0] map_e [logic [7:0]];
  logic [7:0] q [$];
  bit m_ext, m_brk, m_ovf;
  bit par_chk;

  task automatic build_maps();
    logic [7:0] letters [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                                 8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                                 8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
    logic [7:0] digits [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
    for (int i = 0; i < 26; i++) map_n[letters[i]] = 8'h41 + 8'(i);
    for (int i = 0; i < 10; i++) map_n[digits[i]]  = 8'h30 + 8'(i);
    map_n[8'h29] = 8'h20; map_n[8'h5A] = 8'h0D; map_n[8'h66] = 8'h08;
    map_e[8'h75] = 8'h80; map_e[8'h72] = 8'h81; map_e[8'h6B] = 8'h82; map_e[8'h74] = 8'h83;
  endtask

  // bad[0]: parity flipped, bad[1]: stop bit 0
  task automatic model_byte(input logic [7:0] b, input logic [1:0] bad);
    if (bad[1] || (bad[0] && par_chk)) return;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (!m_brk) begin
        if (m_ext ? map_e.exists(b) : map_n.exists(b)) begin
          if (q.size() == DEPTH) m_ovf = 1;
          else q.push_back(m_ext ? map_e[b] : map_n[b]);
        end
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic model_pop();
    if (q.size() > 0) begin
      void'(q.pop_front());
      m_ovf = 0;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".interrupt"}, interrupt, (q.size() != 0));
    check({tag, ".ascii"}, ascii_code, (q.size() != 0) ? q[0] : 8'h00);
    check({tag, ".overflow"}, overflow, m_ovf);
  endtask

  // ---------------- stimulus ----------------
  // mode 0: plain; 1: measure cycles from last ps2c fall to interrupt;
  // 2: pulse DoRead in the cycle the decoded code is written to the FIFO.
  task automatic send_frame(input logic [7:0] b, input logic [1:0] bad, input int mode,
                            output int lat);
    logic [10:0] bits;
    bits = {~bad[1], (~^b) ^ bad[0], b, 1'b0};
    lat = 0;
    for (int k = 0; k < 11; k++) begin
      ps2d = bits[k];
      repeat (20) @(negedge clk);
      ps2c = 1'b0;
      for (int i = 1; i <= 20; i++) begin
        @(negedge clk);
        if (mode == 1 && k == 10 && lat == 0 && interrupt) lat = i;
        if (mode == 2) DoRead = (k == 10 && i == F + 4);
      end
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    int lat;
    send_frame(b, 2'b00, 0, lat);
    model_byte(b, 2'b00);
  endtask

  task automatic send_partial(input logic [7:0] b, input int ndata);
    logic [8:0] bits;
    bits = {b, 1'b0};
    for (int k = 0; k <= ndata; k++) begin
      ps2d = bits[k];
      repeat (20) @(negedge clk);
      ps2c = 1'b0;
      repeat (20) @(negedge clk);
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
  endtask

  task automatic do_read(input string tag);
    DoRead = 1'b1;
    @(negedge clk);
    DoRead = 1'b0;
    model_pop();
    check_state(tag);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 1; i++) do_read(tag);
  endtask

  initial begin
    int lat, fe0, waited;
    logic [7:0] pool [20] = '{8'h1C,8'h32,8'h45,8'h16,8'h29,8'h5A,8'h66,8'hE0,8'hE0,8'hF0,
                              8'hF0,8'h75,8'h72,8'h6B,8'h74,8'h05,8'h76,8'h7D,8'h4D,8'h1A};
`ifdef PS2_PARITY_CHECK_EN
    par_chk = 1;
`else
    par_chk = 0;
`endif
    build_maps();

    // reset state
    repeat (3) @(negedge clk);
    check_state("reset");
    check("reset.frame_err", frame_err, 1'b0);
    Reset = 1'b1;
    repeat (5) @(negedge clk);

    // single make code, latency to interrupt, pop to empty
    send_frame(8'h1C, 2'b00, 1, lat);
    model_byte(8'h1C, 2'b00);
    check("latency", lat, F + 5);
    check_state("make_1C");
    do_read("pop_1C");

    // break and extended prefixes
    send(8'h1C); send(8'hF0); send(8'h1C);
    check_state("brk_seq");
    drain("brk_drain");
    send(8'hE0); send(8'h6B); send(8'hE0); send(8'hF0); send(8'h6B);
    check_state("ext_seq");
    drain("ext_drain");

    // overflow with six digits, ordered pops
    foreach (pool[i]) if (i < 0) send(pool[i]);
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25); send(8'h2E); send(8'h36);
    check_state("ovf_full");
    drain("ovf_pop");

    // full FIFO with pop coincident with push
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
    check_state("full4");
    send_frame(8'h24, 2'b00, 2, lat);
    model_pop();
    model_byte(8'h24, 2'b00);
    check_state("push_pop_full");
    drain("push_pop_drain");

    // flipped parity
    fe0 = fe_cnt;
    send_frame(8'h1C, 2'b01, 0, lat);
    model_byte(8'h1C, 2'b01);
    check("parity.frame_err", fe_cnt - fe0, par_chk ? 1 : 0);
    check_state("parity");
    drain("parity_drain");

    // bad stop bit
    fe0 = fe_cnt;
    send_frame(8'h1C, 2'b10, 0, lat);
    model_byte(8'h1C, 2'b10);
    check("stop.frame_err", fe_cnt - fe0, 1);
    check_state("stop");

    // timeout after 5 data bits, then recovery
    fe0 = fe_cnt;
    send_partial(8'h1C, 5);
    waited = 0;
    while (fe_cnt == fe0 && waited < TO + 200) begin
      @(negedge clk);
      waited++;
    end
    check("timeout.seen", (fe_cnt != fe0), 1'b1);
    check("timeout.not_early", (waited > TO - 100), 1'b1);
    repeat (5) @(negedge clk);
    check("timeout.frame_err_width", fe_cnt - fe0, 1);
    check_state("timeout");
    send(8'h29);
    check_state("after_timeout");

    // reset mid-frame with a non-empty FIFO
    send(8'h1C);
    send_partial(8'h32, 3);
    Reset = 1'b0;
    #1;
    q.delete(); m_ext = 0; m_brk = 0; m_ovf = 0;
    check_state("midreset");
    check("midreset.frame_err", frame_err, 1'b0);
    repeat (3) @(negedge clk);
    Reset = 1'b1;
    repeat (20) @(negedge clk);
    send(8'h29);
    check_state("after_reset");
    drain("after_reset_drain");

    // randomized traffic
    fe0 = fe_cnt;
    for (int n = 0; n < 40; n++) begin
      send(pool[$urandom_range(0, 19)]);
      check_state("rand_frame");
      if ($urandom_range(0, 9) < 4) do_read("rand_read");
    end
    check("rand.frame_err", fe_cnt - fe0, 0);
    drain("rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
